// File: rtl/seg_scan_pkg.sv
// Shared widths and types for the seven-segment scan controller.
package seg_scan_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int NIB_W      = 4;

    typedef logic [NIB_W-1:0] nibble_t;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Digit-slot prescaler: counts enabled cycles 0..TICK_DIV-1 and strobes at terminal count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    if (TICK_DIV == 0) begin : g_bad_div
        $error("tick_gen: TICK_DIV must be at least 1");
    end
    if ((64'(TICK_DIV) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("tick_gen: CNT_W too narrow for TICK_DIV");
    end

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Combinational strobe; the owner registers it so sel and tick move on the same edge.
    assign tick = en && (cnt_q == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == TERM) cnt_q <= '0;
            else               cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit scan controller: digit register file plus slot select feeding the hex decoder.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_addr,
    input  logic [NIB_W-1:0]      wr_data,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [NIB_W-1:0]      digit_o,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  blank_o,
    output logic                  tick_o
);
    logic [NUM_DIGITS-1:0][NIB_W-1:0] regs_q;
    sel_t                             sel_q;
    logic                             tick_q;
    logic                             adv;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (scan_en),
        .tick  (adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[wr_addr] <= wr_data;
            tick_q <= adv;
            if (adv) sel_q <= sel_t'(sel_q + 1'b1);
        end
    end

    // Read ports are combinational off registered state, so a same-edge write and
    // slot advance both show up in the first cycle of the new slot.
    assign digit_o = regs_q[sel_q];
    assign blank_o = blank_mask[sel_q];
    assign sel_o   = sel_q;
    assign tick_o  = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table of cycle vectors plus hand sequences.
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] blank_mask;
    logic [3:0] digit4, digit1;
    logic [2:0] sel4, sel1;
    logic       blank4, blank1, tick4, tick1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.TICK_DIV(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .blank_mask(blank_mask),
        .digit_o(digit4), .sel_o(sel4), .blank_o(blank4), .tick_o(tick4)
    );

    seg_scan_ctrl #(.TICK_DIV(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .blank_mask(blank_mask),
        .digit_o(digit1), .sel_o(sel1), .blank_o(blank1), .tick_o(tick1)
    );

    typedef struct packed {
        logic       en;
        logic       wr;
        logic [2:0] addr;
        logic [3:0] data;
        logic [2:0] sel;
        logic [3:0] dig;
        logic       tick;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic en, input logic wr, input logic [2:0] addr,
                                input logic [3:0] data, input logic [2:0] sel,
                                input logic [3:0] dig, input logic tick);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.data = data;
        v.sel = sel; v.dig = dig; v.tick = tick;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] es;

        // TICK_DIV=4 scan with writes; starts at sel=1, prescaler 0, regs[i]=i+1
        tbl[0]  = mk(1, 0, 0, 0,   1, 2,   0);
        tbl[1]  = mk(1, 0, 0, 0,   1, 2,   0);
        tbl[2]  = mk(1, 0, 0, 0,   1, 2,   0);
        tbl[3]  = mk(1, 0, 0, 0,   2, 3,   1);
        tbl[4]  = mk(1, 0, 0, 0,   2, 3,   0);
        tbl[5]  = mk(1, 0, 0, 0,   2, 3,   0);
        tbl[6]  = mk(1, 0, 0, 0,   2, 3,   0);
        tbl[7]  = mk(1, 0, 0, 0,   3, 4,   1);
        tbl[8]  = mk(1, 1, 3, 4'hF, 3, 4'hF, 0);  // write to shown digit
        tbl[9]  = mk(1, 0, 0, 0,   3, 4'hF, 0);
        tbl[10] = mk(1, 0, 0, 0,   3, 4'hF, 0);
        tbl[11] = mk(1, 1, 4, 4'hA, 4, 4'hA, 1);  // write to next index on tick edge
        tbl[12] = mk(0, 0, 0, 0,   4, 4'hA, 0);

        rst_n = 1'b0; scan_en = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; blank_mask = 8'h00;
        #3;
        chk("rst_sel",   {5'd0, sel4},   8'd0);
        chk("rst_digit", {4'd0, digit4}, 8'd0);
        chk("rst_tick",  {7'd0, tick4},  8'd0);
        chk("rst_blank", {7'd0, blank4}, 8'd0);
        rst_n = 1'b1;
        scan_en = 1'b1;

        // Test 1: tick every 4th cycle, sel walks 0..7 and wraps
        for (int k = 0; k < 36; k++) begin
            step();
            chk("t1_tick", {7'd0, tick4}, {7'd0, logic'((k % 4) == 3)});
            chk("t1_sel",  {5'd0, sel4},  8'(((k + 1) / 4) % 8));
        end

        // Test 2: load digits while scan held, then table-driven scan
        scan_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
            step();
        end
        wr_en = 1'b0;
        chk("t2_hold_sel", {5'd0, sel4},   8'd1);
        chk("t2_digit1",   {4'd0, digit4}, 8'd2);

        for (int i = 0; i < 13; i++) begin
            scan_en = tbl[i].en; wr_en = tbl[i].wr;
            wr_addr = tbl[i].addr; wr_data = tbl[i].data;
            step();
            chk($sformatf("tbl%0d_sel", i),   {5'd0, sel4},   {5'd0, tbl[i].sel});
            chk($sformatf("tbl%0d_digit", i), {4'd0, digit4}, {4'd0, tbl[i].dig});
            chk($sformatf("tbl%0d_tick", i),  {7'd0, tick4},  {7'd0, tbl[i].tick});
            chk($sformatf("tbl%0d_blank", i), {7'd0, blank4}, 8'd0);
        end
        wr_en = 1'b0;

        // Test 3: pause two cycles into slot 4, resume, tick two cycles later
        scan_en = 1'b1;
        step(); step();
        chk("t3_pre_sel", {5'd0, sel4}, 8'd4);
        scan_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t3_frz_sel",  {5'd0, sel4},  8'd4);
            chk("t3_frz_tick", {7'd0, tick4}, 8'd0);
        end
        scan_en = 1'b1;
        step();
        chk("t3_res1_tick", {7'd0, tick4}, 8'd0);
        chk("t3_res1_sel",  {5'd0, sel4},  8'd4);
        step();
        chk("t3_res2_tick",  {7'd0, tick4},  8'd1);
        chk("t3_res2_sel",   {5'd0, sel4},   8'd5);
        chk("t3_res2_digit", {4'd0, digit4}, 8'd6);

        // Test 4: blanking follows the mask per slot
        blank_mask = 8'b1010_0101;
        #1;
        chk("t4_blank_s5", {7'd0, blank4}, 8'd1);
        for (int k = 0; k < 32; k++) begin
            step();
            es = 3'((5 + (k + 1) / 4) % 8);
            chk("t4_sel",   {5'd0, sel4},   {5'd0, es});
            chk("t4_blank", {7'd0, blank4},
                {7'd0, logic'(es == 0 || es == 2 || es == 5 || es == 7)});
        end

        // Test 5: async reset between edges while sel=6 with tick high
        for (int k = 0; k < 4; k++) step();
        chk("t5_pre_sel",  {5'd0, sel4},  8'd6);
        chk("t5_pre_tick", {7'd0, tick4}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sel",   {5'd0, sel4},   8'd0);
        chk("t5_rst_tick",  {7'd0, tick4},  8'd0);
        chk("t5_rst_digit", {4'd0, digit4}, 8'd0);
        chk("t5_rst_blank", {7'd0, blank4}, 8'd1);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_post_tick",  {7'd0, tick4},  {7'd0, logic'(k == 3)});
            chk("t5_post_sel",   {5'd0, sel4},   (k == 3) ? 8'd1 : 8'd0);
            chk("t5_post_digit", {4'd0, digit4}, 8'd0);
        end

        // Test 6: TICK_DIV=1 ticks every enabled cycle, sel wraps 7 -> 0
        rst_n = 1'b0;
        #2;
        chk("t6_rst_tick", {7'd0, tick1}, 8'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6_tick", {7'd0, tick1}, 8'd1);
            chk("t6_sel",  {5'd0, sel1},  8'((k + 1) % 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scanner for the 8-digit seven-segment display.
- Sits directly upstream of the combinational hex-to-segment/anode decoder.
- Holds eight 4-bit digit values written by the host logic.
- Steps a 3-bit digit select at a programmable refresh rate and presents the selected nibble plus the select to the decoder.

Parameters:
- TICK_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 1..2^24-1.
- CNT_W, 24: prescaler counter width; must satisfy 2^CNT_W > TICK_DIV-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scan_en  input  1  1 = prescaler runs; 0 = prescaler and select hold.
- wr_en  input  1  digit register write strobe.
- wr_addr  input  3  digit index to write (0 = rightmost digit).
- wr_data  input  4  hex nibble to store.
- blank_mask  input  8  bit i = 1 forces digit i dark.
- digit_o  output  4  nibble for the decoder; digit_o[3] drives decoder a0 (MSB), digit_o[0] drives a3.
- sel_o  output  3  digit select; sel_o[2] drives decoder sel_0 (MSB), sel_o[0] drives sel_2.
- blank_o  output  1  1 = top level forces all anodes high for the current slot.
- tick_o  output  1  one-cycle pulse when the slot advances.

Behaviour:
- Reset (async assert, sync release internally not required):
  - all 8 digit registers = 4'h0; prescaler = 0; sel_o = 0; tick_o = 0.
  - digit_o = 4'h0; blank_o = blank_mask[0].
- Prescaler:
  - When scan_en = 1, counts 0..TICK_DIV-1.
  - At terminal count it returns to 0 and a tick is issued.
  - TICK_DIV = 1 gives a tick every enabled cycle.
- Tick (registered):
  - tick_o = 1 in the cycle after the prescaler sits at terminal count with scan_en = 1.
  - In the same edge, sel_o increments mod 8 (7 -> 0 wrap).
  - Slot length is exactly TICK_DIV enabled cycles.
- scan_en = 0:
  - prescaler, sel_o and tick_o hold (tick_o forced 0).
  - Resuming continues from the held count; no tick is lost or duplicated.
- Write:
  - On a rising edge with wr_en = 1, regs[wr_addr] <= wr_data.
  - Writes are accepted regardless of scan_en or tick.
- Outputs:
  - digit_o = regs[sel_o] (combinational read of registered state).
  - A write to the currently displayed index appears on digit_o one cycle after the wr_en edge.
  - A write coinciding with a tick to the new index: the new value is visible in the first cycle of the new slot.
  - blank_o = blank_mask[sel_o], combinational.
- Reset mid-scan: all state returns to reset values immediately; scanning restarts at slot 0 with a full TICK_DIV period.
- Elaboration: TICK_DIV = 0 is rejected by an elaboration-time assertion.
- Throughput: no backpressure; decoder latency is 0, so segment/anode change occurs the cycle sel_o changes.

Decomposition:
- Package seg_scan_pkg:
  - NUM_DIGITS = 8, SEL_W = 3, NIB_W = 4.
  - typedef logic [NIB_W-1:0] nibble_t.
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module tick_gen (parameters TICK_DIV and CNT_W; ports clk, rst_n, en, tick) holds the prescaler.
- The digit register file and select counter stay in seg_scan_ctrl.

Test Plan:
1. Reset with blank_mask = 8'h00 -> sel_o = 0, digit_o = 0, tick_o = 0, blank_o = 0. Then TICK_DIV = 4, scan_en = 1 -> tick_o every 4th cycle and sel_o sequence 0,1,...,7,0.
2. Write regs 0..7 = 8'h? values 1,2,...,8 (index i gets i+1), then scan -> digit_o shows 1..8 in lockstep with sel_o; at sel_o = 3 write 4'hF to addr 3 -> digit_o = F the next cycle, with no sel_o change.
3. With TICK_DIV = 4, drop scan_en for 10 cycles two cycles into a slot -> sel_o and tick_o are frozen; after re-enable the next tick arrives exactly 2 cycles later.
4. blank_mask = 8'b1010_0101 -> blank_o = 1 exactly in slots 0, 2, 5, 7 and 0 elsewhere.
5. Assert rst_n low asynchronously (between edges) while sel_o = 6 -> all outputs reach reset values without a clock edge; after release the first tick comes after TICK_DIV cycles with sel_o = 1.
6. TICK_DIV = 1 -> tick_o held high continuously, sel_o increments every cycle and wraps 7 -> 0.
